bus_read_sequencer: RTL and testbench

BUS_READ_SEQUENCER -- requirements
Module: bus_read_sequencer

---
 rtl/bus_read_sequencer.sv | 155 +++++++++++++++
 tb/tb_bus_read_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_read_sequencer.sv
// bus_read_sequencer
//   Sequences reads from four 8-bit tri-state source registers that share one
//   data bus. A read enables one source for a settle cycle (DRIVE), captures
//   the bus at the end of a second cycle (SAMPLE), then holds the byte until
//   the consumer takes it (HOLD, valid/ready handshake). A burst reads
//   sources 0..3 in order; a single read takes the source given by src_sel.
//
// Ports
//   clk       system clock, rising edge
//   clr       synchronous active-high reset
//   start     request pulse, sampled only in IDLE
//   burst     sampled with start: 1 = sources 0..3, 0 = single read
//   src_sel   source index for a single read, sampled with start
//   en_n      active-low source output enables, registered, at most one low
//   bus_in    shared data bus
//   rd_data   captured byte
//   rd_src    source index that produced rd_data
//   rd_valid  rd_data/rd_src valid, held until accepted
//   rd_ready  consumer accepts when rd_valid & rd_ready at a rising edge
//   busy      high in every state except IDLE
//
// Build option
//   DRIVE_GAP_EN  when defined, every exit from HOLD spends one extra cycle in
//                 GAP with all enables high before the next DRIVE or IDLE,
//                 giving the bus a turnaround cycle between sources.

module bus_read_sequencer (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       burst,
  input  logic [1:0] src_sel,
  output logic [3:0] en_n,
  input  logic [7:0] bus_in,
  output logic [7:0] rd_data,
  output logic [1:0] rd_src,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic       busy
);

`ifdef DRIVE_GAP_EN
  typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, HOLD, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, HOLD} state_t;
`endif

  state_t     state_reg, state_next;
  logic [1:0] idx_reg, idx_next;
  logic       mode_reg, mode_next;
  logic [3:0] en_n_reg, en_n_next;
  logic [7:0] rd_data_reg, rd_data_next;
  logic [1:0] rd_src_reg, rd_src_next;
  logic       rd_valid_reg, rd_valid_next;
  logic       busy_reg, busy_next;
  logic       drive_next;

  // State register: every output is a flop so en_n cannot glitch.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg    <= IDLE;
      idx_reg      <= 2'd0;
      mode_reg     <= 1'b0;
      en_n_reg     <= 4'b1111;
      rd_data_reg  <= 8'h00;
      rd_src_reg   <= 2'd0;
      rd_valid_reg <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      mode_reg     <= mode_next;
      en_n_reg     <= en_n_next;
      rd_data_reg  <= rd_data_next;
      rd_src_reg   <= rd_src_next;
      rd_valid_reg <= rd_valid_next;
      busy_reg     <= busy_next;
    end
  end

  // Next-state logic. When a transaction finishes, mode is cleared so that
  // GAP can tell "burst continues" (mode=1) from "done" (mode=0) without
  // looking at idx, which is 3 in both the last-continue and done cases.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    mode_next  = mode_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = DRIVE;
          idx_next   = burst ? 2'd0 : src_sel;
          mode_next  = burst;
        end
      end
      DRIVE:  state_next = SAMPLE;
      SAMPLE: state_next = HOLD;
      HOLD: begin
        if (rd_ready) begin
          if (mode_reg && (idx_reg != 2'd3)) begin
            idx_next = idx_reg + 2'd1;
`ifdef DRIVE_GAP_EN
            state_next = GAP;
`else
            state_next = DRIVE;
`endif
          end else begin
            mode_next = 1'b0;
`ifdef DRIVE_GAP_EN
            state_next = GAP;
`else
            state_next = IDLE;
`endif
          end
        end
      end
`ifdef DRIVE_GAP_EN
      GAP: state_next = mode_reg ? DRIVE : IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, derived from the
  // state being entered so they line up with the state register.
  assign drive_next = (state_next == DRIVE) || (state_next == SAMPLE);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_en
      assign en_n_next[gi] = !(drive_next && (idx_next == 2'(gi)));
    end
  endgenerate

  always_comb begin
    rd_data_next  = rd_data_reg;
    rd_src_next   = rd_src_reg;
    rd_valid_next = rd_valid_reg;
    busy_next     = (state_next != IDLE);
    if (state_reg == SAMPLE) begin
      rd_data_next  = bus_in;
      rd_src_next   = idx_reg;
      rd_valid_next = 1'b1;
    end else if ((state_reg == HOLD) && rd_ready) begin
      rd_valid_next = 1'b0;
    end
  end

  assign en_n     = en_n_reg;
  assign rd_data  = rd_data_reg;
  assign rd_src   = rd_src_reg;
  assign rd_valid = rd_valid_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_bus_read_sequencer.sv
module tb_bus_read_sequencer;

`ifdef DRIVE_GAP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif

  logic       clk = 1'b0;
  logic       clr, start, burst, rd_ready;
  logic [1:0] src_sel;
  logic [3:0] en_n;
  logic [7:0] bus_in, rd_data;
  logic [1:0] rd_src;
  logic       rd_valid, busy;

  logic [7:0] src_val [4];
  logic [9:0] exp_q [$];
  int         pop_cyc [$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         n_pops = 0;
  int         cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_read_sequencer dut (
    .clk(clk), .clr(clr), .start(start), .burst(burst), .src_sel(src_sel),
    .en_n(en_n), .bus_in(bus_in), .rd_data(rd_data), .rd_src(rd_src),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .busy(busy)
  );

  // Tri-state source model: the enabled register drives the bus.
  always_comb begin
    case (en_n)
      4'b1110: bus_in = src_val[0];
      4'b1101: bus_in = src_val[1];
      4'b1011: bus_in = src_val[2];
      4'b0111: bus_in = src_val[3];
      default: bus_in = 8'hEE;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: each accepted transfer pops the scoreboard; enable sanity each cycle.
  always @(negedge clk) begin
    check("en_n_onehot", ($countones(~en_n) <= 1) ? 32'd1 : 32'd0, 32'd1);
    if (rd_valid && rd_ready && !clr) begin
      n_pops++;
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_xfer", {22'd0, rd_src, rd_data}, 32'hFFFF);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("xfer", {22'd0, rd_src, rd_data}, {22'd0, e});
        $display("xfer src=%0d data=%02h expected src=%0d data=%02h", rd_src, rd_data, e[9:8], e[7:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int maxc);
    int k = 0;
    while (busy && k < maxc) begin tick(); k++; end
    check("idle_timeout", busy, 0);
  endtask

  task automatic wait_valid(input int maxc);
    int k = 0;
    while (!rd_valid && k < maxc) begin tick(); k++; end
    check("valid_timeout", rd_valid, 1);
  endtask

  initial begin
    src_val[0] = 8'h11; src_val[1] = 8'h22; src_val[2] = 8'h33; src_val[3] = 8'h44;
    clr = 1'b1; start = 1'b0; burst = 1'b0; src_sel = 2'd0; rd_ready = 1'b0;
    repeat (3) tick();
    clr = 1'b0;
    check("rst_en_n", en_n, 4'hF);
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 8'h00);
    check("rst_src", rd_src, 0);
    check("rst_busy", busy, 0);

    // Single read of source 2, latency 3.
    src_val[2] = 8'hA5;
    src_sel = 2'd2; burst = 1'b0; rd_ready = 1'b1; start = 1'b1;
    exp_q.push_back({2'd2, 8'hA5});
    tick(); start = 1'b0;
    check("single_en_c1", en_n, 4'b1011);
    check("single_busy", busy, 1);
    check("single_valid_c1", rd_valid, 0);
    tick();
    check("single_en_c2", en_n, 4'b1011);
    tick();
    check("single_valid_c3", rd_valid, 1);
    check("single_data_c3", rd_data, 8'hA5);
    check("single_src_c3", rd_src, 2);
    check("single_en_hold", en_n, 4'hF);
    tick();
    check("single_valid_after", rd_valid, 0);
    check("single_busy_after", busy, GAP);
    wait_idle(10);
    src_val[2] = 8'h33;

    // Burst of four with ready high: bytes every 3 (+gap) cycles.
    pop_cyc.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back({2'(i), src_val[i]});
    burst = 1'b1; start = 1'b1;
    tick(); start = 1'b0; burst = 1'b0;
    wait_idle(40);
    check("burst_count", pop_cyc.size(), 4);
    if (pop_cyc.size() == 4)
      for (int i = 1; i < 4; i++) check("burst_spacing", pop_cyc[i] - pop_cyc[i-1], 3 + GAP);

    // Backpressure: hold for 5 cycles, then exactly one transfer.
    rd_ready = 1'b0; src_sel = 2'd1; start = 1'b1;
    exp_q.push_back({2'd1, 8'h22});
    tick(); start = 1'b0;
    wait_valid(10);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", rd_valid, 1);
      check("bp_data", rd_data, 8'h22);
      check("bp_src", rd_src, 1);
      check("bp_en_n", en_n, 4'hF);
      tick();
    end
    rd_ready = 1'b1;
    tick();
    check("bp_released", rd_valid, 0);
    wait_idle(10);

    // start while busy (DRIVE and HOLD) is ignored.
    begin
      int n0;
      n0 = n_pops;
      rd_ready = 1'b0; src_sel = 2'd3; start = 1'b1;
      exp_q.push_back({2'd3, 8'h44});
      tick();
      burst = 1'b1; src_sel = 2'd0;
      tick(); start = 1'b0; burst = 1'b0;
      wait_valid(10);
      start = 1'b1; tick(); start = 1'b0;
      tick(); rd_ready = 1'b1;
      tick();
      wait_idle(10);
      repeat (8) tick();
      check("ignore_one_xfer", n_pops - n0, 1);
      check("ignore_idle", busy, 0);
    end

    // clr in SAMPLE of burst byte 2: abandoned, nothing more delivered.
    begin
      int k = 0;
      burst = 1'b1; start = 1'b1; rd_ready = 1'b1;
      exp_q.push_back({2'd0, 8'h11});
      tick(); start = 1'b0; burst = 1'b0;
      while (en_n != 4'b1101 && k < 20) begin tick(); k++; end
      check("clr_reach_byte2", en_n, 4'b1101);
      tick();
      clr = 1'b1;
      tick(); clr = 1'b0;
      check("clr_en_n", en_n, 4'hF);
      check("clr_valid", rd_valid, 0);
      check("clr_data", rd_data, 8'h00);
      check("clr_src", rd_src, 0);
      check("clr_busy", busy, 0);
      repeat (6) tick();
      check("clr_no_byte", rd_valid, 0);
    end

    // Next start after clr works normally.
    src_sel = 2'd0; start = 1'b1;
    exp_q.push_back({2'd0, 8'h11});
    tick(); start = 1'b0;
    check("post_clr_en", en_n, 4'b1110);
    wait_idle(10);

    // start and clr together: clr wins.
    start = 1'b1; clr = 1'b1;
    tick(); start = 1'b0; clr = 1'b0;
    check("clr_start_busy", busy, 0);
    check("clr_start_en", en_n, 4'hF);
    repeat (5) tick();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
